bcd_combinational: RTL and testbench

BCD_COMBINATIONAL -- requirements
Module: bcd_combinational

---
 rtl/bcd_combinational.sv | 54 +++++
 tb/tb_bcd_combinational.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd_combinational.sv
// Purpose: converts an 8-bit unsigned binary value into hundreds/tens/units BCD digits.
// Latency: digits are combinational (0 cycles); the *_q copies follow 1 cycle later.
// Backpressure: none; a new value is accepted and converted every cycle.
module bcd_combinational (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [1:0] hundreds,
  output logic [3:0] units_q,
  output logic [3:0] tens_q,
  output logic [1:0] hundreds_q
);

  // A BCD digit of 5 or more becomes 10 or more after the next shift. Adding 3
  // first makes the shift carry correctly into the next digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Scratch vector for the unrolled conversion.
  // Bits [7:0] hold the binary value still to be shifted in.
  // Bits [11:8] hold units, [15:12] hold tens and [17:16] hold hundreds.
  // For inputs up to 255 the hundreds digit never exceeds 2, so two bits suffice
  // and nothing is lost off the top on the final shift.
  logic [17:0] w_shift;

  // Double dabble, unrolled over 8 bit-stages: adjust the digits, then shift left once per stage.
  always_comb begin
    w_shift = {10'd0, data};
    for (int i = 0; i < 8; i++) begin
      w_shift = {w_shift[17:16], add3(w_shift[15:12]), add3(w_shift[11:8]), w_shift[7:0]};
      w_shift = {w_shift[16:0], 1'b0};
    end
    units    = w_shift[11:8];
    tens     = w_shift[15:12];
    hundreds = w_shift[17:16];
  end

  // Registered copy of the digits; a synchronous reset clears only these registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      units_q    <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 2'd0;
    end else begin
      units_q    <= units;
      tens_q     <= tens;
      hundreds_q <= hundreds;
    end
  end

endmodule

// File: tb/tb_bcd_combinational.sv
module tb_bcd_combinational;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic [3:0] units;
  logic [3:0] tens;
  logic [1:0] hundreds;
  logic [3:0] units_q;
  logic [3:0] tens_q;
  logic [1:0] hundreds_q;

  int tests;
  int failed;

  bcd_combinational dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .units      (units),
    .tens       (tens),
    .hundreds   (hundreds),
    .units_q    (units_q),
    .tens_q     (tens_q),
    .hundreds_q (hundreds_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The bench's own reference model: the expected digit triple of v, packed as {h,t,u}.
  function automatic logic [9:0] ref_bcd(input int v);
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] u;
    h = 2'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed h=%0d t=%0d u=%0d expected h=%0d t=%0d u=%0d",
             tag, obs[9:8], obs[7:4], obs[3:0], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask

  function automatic logic [9:0] comb_now();
    return {hundreds, tens, units};
  endfunction

  function automatic logic [9:0] reg_now();
    return {hundreds_q, tens_q, units_q};
  endfunction

  // Directed vectors: each input value with its hand-computed digits.
  logic [7:0] dir_val [8];
  logic [9:0] dir_exp [8];

  initial begin
    int prev;
    bit prev_rst;
    int sum;
    logic [9:0] exp_reg;

    tests  = 0;
    failed = 0;

    dir_val[0] = 8'd0;   dir_exp[0] = {2'd0, 4'd0, 4'd0};
    dir_val[1] = 8'd9;   dir_exp[1] = {2'd0, 4'd0, 4'd9};
    dir_val[2] = 8'd10;  dir_exp[2] = {2'd0, 4'd1, 4'd0};
    dir_val[3] = 8'd99;  dir_exp[3] = {2'd0, 4'd9, 4'd9};
    dir_val[4] = 8'd100; dir_exp[4] = {2'd1, 4'd0, 4'd0};
    dir_val[5] = 8'd199; dir_exp[5] = {2'd1, 4'd9, 4'd9};
    dir_val[6] = 8'd200; dir_exp[6] = {2'd2, 4'd0, 4'd0};
    dir_val[7] = 8'd255; dir_exp[7] = {2'd2, 4'd5, 4'd5};

    // Reset with data held at 137: the registers clear, the digits are unaffected.
    reset = 1'b1;
    data  = 8'd137;
    @(posedge clk); #1;
    check("reset_reg_zero", reg_now(), {2'd0, 4'd0, 4'd0});
    check("reset_comb_137", comb_now(), {2'd1, 4'd3, 4'd7});

    // The first edge after reset is released loads the current conversion.
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("first_load_137", reg_now(), {2'd1, 4'd3, 4'd7});

    // Directed combinational values, including the hundreds boundaries.
    foreach (dir_val[i]) begin
      @(negedge clk); data = dir_val[i]; #1;
      check($sformatf("comb_%0d", dir_val[i]), comb_now(), dir_exp[i]);
    end

    // Wrap from 255 to 0: the digits change at once, the registers one edge later.
    @(negedge clk); data = 8'd255;
    @(posedge clk); #1;
    check("wrap_reg_255", reg_now(), {2'd2, 4'd5, 4'd5});
    @(negedge clk); data = 8'd0; #1;
    check("wrap_comb_0", comb_now(), {2'd0, 4'd0, 4'd0});
    check("wrap_reg_hold", reg_now(), {2'd2, 4'd5, 4'd5});
    @(posedge clk); #1;
    check("wrap_reg_0", reg_now(), {2'd0, 4'd0, 4'd0});

    // Single-edge reset while data is held at 137.
    @(negedge clk); data = 8'd137; reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_reg_zero", reg_now(), {2'd0, 4'd0, 4'd0});
    check("midrst_comb_137", comb_now(), {2'd1, 4'd3, 4'd7});
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_reg_137", reg_now(), {2'd1, 4'd3, 4'd7});

    // Full sweep 0..255, wrapping back to 0. Reset is pulsed on the edge after data=128.
    prev     = -1;
    prev_rst = 1'b0;
    for (int v = 0; v <= 256; v++) begin
      @(negedge clk);
      data  = 8'(v % 256);
      reset = (v == 128);
      #1;
      sum = 100 * int'(hundreds) + 10 * int'(tens) + int'(units);
      tests++;
      assert (sum == (v % 256)) else begin
        failed++;
        $error("FAIL sweep_sum_%0d: observed %0d expected %0d", v % 256, sum, v % 256);
      end
      tests++;
      assert ((units <= 4'd9) && (tens <= 4'd9) && (hundreds <= 2'd2)) else begin
        failed++;
        $error("FAIL sweep_legal_%0d: observed h=%0d t=%0d u=%0d expected each digit in range",
               v % 256, hundreds, tens, units);
      end
      if (prev >= 0) begin
        exp_reg = prev_rst ? 10'd0 : ref_bcd(prev);
        check($sformatf("sweep_reg_%0d", v % 256), reg_now(), exp_reg);
      end
      prev     = v % 256;
      prev_rst = (v == 128);
    end
    @(negedge clk); reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
